// File: rtl/pe_row_pkg.sv
// Shared types and helpers for the output-stationary MAC row.
package pe_row_pkg;

  typedef enum logic [1:0] {RUN, FLUSH, DRAIN} state_t;

  // Widest accumulator the drain path can scale/saturate.
  localparam int unsigned MAX_W      = 128;
  localparam int unsigned DEF_NUM_PE = 4;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned IDX_W = idx_width(DEF_NUM_PE);

  typedef struct packed {
    logic             hit;
    logic [MAX_W-1:0] val;
  } sat_t;

  // Clamp an already sign/zero-extended value into a dw-bit result range.
  function automatic sat_t saturate(input logic [MAX_W-1:0] v,
                                    input logic             is_signed,
                                    input int unsigned      dw);
    logic signed [MAX_W-1:0] sv;
    logic signed [MAX_W-1:0] hi;
    logic signed [MAX_W-1:0] lo;
    logic        [MAX_W-1:0] umax;
    sat_t r;
    sv    = signed'(v);
    hi    = signed'((MAX_W'(1) << (dw - 1)) - MAX_W'(1));
    lo    = ~hi;
    umax  = (MAX_W'(1) << dw) - MAX_W'(1);
    r.hit = 1'b0;
    r.val = v;
    if (is_signed) begin
      if (sv > hi) begin
        r.hit = 1'b1;
        r.val = hi;
      end else if (sv < lo) begin
        r.hit = 1'b1;
        r.val = lo;
      end
    end else if (v > umax) begin
      r.hit = 1'b1;
      r.val = umax;
    end
    return r;
  endfunction

endpackage

// File: rtl/pe_row_mac.sv
// One MAC cell: skew register for the east-bound operand plus a wide accumulator.
module pe_mac import pe_row_pkg::*; #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ACC_WIDTH  = 40
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_clear,
  input  logic                  i_acc_clr,
  input  logic                  i_mode_signed,
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_b,
  output logic [DATA_WIDTH-1:0] o_a,
  output logic                  o_valid,
  output logic [ACC_WIDTH-1:0]  o_acc
);

  logic [DATA_WIDTH-1:0]   r_a;
  logic                    r_valid;
  logic [ACC_WIDTH-1:0]    r_acc;
  logic [2*DATA_WIDTH-1:0] w_ax;
  logic [2*DATA_WIDTH-1:0] w_bx;
  logic [2*DATA_WIDTH-1:0] w_prod;
  logic [ACC_WIDTH-1:0]    w_ext;

  // Extending operands first keeps one multiplier for both modes.
  always_comb begin
    if (i_mode_signed) begin
      w_ax = (2*DATA_WIDTH)'(signed'(i_a));
      w_bx = (2*DATA_WIDTH)'(signed'(i_b));
    end else begin
      w_ax = (2*DATA_WIDTH)'(i_a);
      w_bx = (2*DATA_WIDTH)'(i_b);
    end
    w_prod = w_ax * w_bx;
    w_ext  = i_mode_signed ? ACC_WIDTH'(signed'(w_prod)) : ACC_WIDTH'(w_prod);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_a     <= '0;
      r_valid <= 1'b0;
      r_acc   <= '0;
    end else begin
      r_a     <= i_a;
      r_valid <= i_clear ? 1'b0 : i_valid;
      if (i_clear || i_acc_clr) begin
        r_acc <= '0;
      end else if (i_valid) begin
        r_acc <= r_acc + w_ext;
      end
    end
  end

  assign o_a     = r_a;
  assign o_valid = r_valid;
  assign o_acc   = r_acc;

endmodule

// File: rtl/pe_row.sv
// Output-stationary row of NUM_PE MAC cells with a skewed left-operand chain
// and a single scaled/saturated drain port that re-arms after the last result.
module pe_row import pe_row_pkg::*; #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ACC_WIDTH  = 40,
  parameter int unsigned NUM_PE     = 4,
  parameter int unsigned FRAC_SHIFT = 0
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           mode_signed,
  input  logic                           clear,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [DATA_WIDTH-1:0]          a_in,
  input  logic [NUM_PE*DATA_WIDTH-1:0]   b_in,
  output logic [DATA_WIDTH-1:0]          a_out,
  output logic                           a_out_valid,
  input  logic                           drain_start,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [DATA_WIDTH-1:0]          out_data,
  output logic [idx_width(NUM_PE)-1:0]   out_idx,
  output logic                           out_last,
  output logic                           sat_flag
);

  localparam int unsigned          IDX_BITS = idx_width(NUM_PE);
  localparam logic [IDX_BITS-1:0]  LAST_IDX = IDX_BITS'(NUM_PE - 1);

  if (ACC_WIDTH < 2*DATA_WIDTH || ACC_WIDTH >= MAX_W || NUM_PE < 1) begin : g_bad_params
    $error("pe_row: need NUM_PE >= 1 and 2*DATA_WIDTH <= ACC_WIDTH < MAX_W");
  end

  state_t                  r_state;
  state_t                  w_next;
  logic [IDX_BITS-1:0]     r_cnt;
  logic [IDX_BITS-1:0]     r_idx;
  logic                    r_sat;
  logic                    w_hs;
  logic                    w_acc_clr;
  logic [DATA_WIDTH-1:0]   w_a   [NUM_PE+1];
  logic                    w_v   [NUM_PE+1];
  logic [ACC_WIDTH-1:0]    w_acc [NUM_PE];
  logic [ACC_WIDTH-1:0]    w_acc_sel;
  logic signed [MAX_W-1:0] w_ext_s;
  logic [MAX_W-1:0]        w_shift;
  sat_t                    w_sat;
  logic                    w_unused_sat;

  assign w_a[0] = a_in;
  assign w_v[0] = in_valid && in_ready;

  for (genvar k = 0; k < NUM_PE; k++) begin : g_cell
    pe_mac #(
      .DATA_WIDTH (DATA_WIDTH),
      .ACC_WIDTH  (ACC_WIDTH)
    ) u_mac (
      .clk           (clk),
      .reset_n       (reset_n),
      .i_clear       (clear),
      .i_acc_clr     (w_acc_clr),
      .i_mode_signed (mode_signed),
      .i_a           (w_a[k]),
      .i_valid       (w_v[k]),
      .i_b           (b_in[k*DATA_WIDTH +: DATA_WIDTH]),
      .o_a           (w_a[k+1]),
      .o_valid       (w_v[k+1]),
      .o_acc         (w_acc[k])
    );
  end

  assign a_out       = w_a[NUM_PE];
  assign a_out_valid = w_v[NUM_PE];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= RUN;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (clear) begin
      w_next = RUN;
    end else begin
      case (r_state)
        RUN:     if (drain_start) w_next = (NUM_PE == 1) ? DRAIN : FLUSH;
        FLUSH:   if (r_cnt == '0) w_next = DRAIN;
        DRAIN:   if (w_hs && r_idx == LAST_IDX) w_next = RUN;
        default: w_next = RUN;
      endcase
    end
  end

  always_comb begin
    in_ready  = (r_state == RUN);
    out_valid = (r_state == DRAIN);
    out_last  = (r_state == DRAIN) && (r_idx == LAST_IDX);
  end

  assign w_hs      = out_valid && out_ready;
  assign w_acc_clr = w_hs && out_last;

  // FLUSH length counter, drain index and sticky saturation flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
      r_idx <= '0;
      r_sat <= 1'b0;
    end else if (clear) begin
      r_cnt <= '0;
      r_idx <= '0;
      r_sat <= 1'b0;
    end else begin
      if (r_state == RUN && drain_start) begin
        r_cnt <= IDX_BITS'(NUM_PE - 2);
        r_idx <= '0;
      end else if (r_state == FLUSH && r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_hs) begin
        r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
        if (w_sat.hit) r_sat <= 1'b1;
      end
    end
  end

  always_comb begin
    w_acc_sel = w_acc[r_idx];
    w_ext_s   = MAX_W'(signed'(w_acc_sel));
    if (mode_signed) w_shift = w_ext_s >>> FRAC_SHIFT;
    else             w_shift = MAX_W'(w_acc_sel) >> FRAC_SHIFT;
    w_sat     = saturate(w_shift, mode_signed, DATA_WIDTH);
  end

  assign out_data     = w_sat.val[DATA_WIDTH-1:0];
  assign w_unused_sat = ^w_sat.val[MAX_W-1:DATA_WIDTH];
  assign out_idx      = r_idx;
  assign sat_flag     = r_sat;

endmodule

// File: tb/tb_pe_row.sv
// Randomized self-checking bench for pe_row against an integer dot-product model.
module tb_pe_row;

  localparam int unsigned DW  = 16;
  localparam int unsigned AW  = 40;
  localparam int unsigned NPE = 4;
  localparam int unsigned FS  = 0;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            mode_signed;
  logic            clear;
  logic            in_valid;
  logic            in_ready;
  logic [DW-1:0]   a_in;
  logic [NPE*DW-1:0] b_in;
  logic [DW-1:0]   a_out;
  logic            a_out_valid;
  logic            drain_start;
  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   out_data;
  logic [1:0]      out_idx;
  logic            out_last;
  logic            sat_flag;

  int n_vec = 0;
  int n_err = 0;

  longint        model_acc [NPE];
  logic          model_sat;
  logic [DW-1:0] exp_d     [NPE];
  logic [DW-1:0] got_data  [NPE];
  logic [1:0]    got_idx   [NPE];
  logic          got_last  [NPE];
  int            got_lat, got_n, got_unstable;
  logic          got_timeout;

  pe_row #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .NUM_PE(NPE), .FRAC_SHIFT(FS)) dut (
    .clk(clk), .reset_n(reset_n), .mode_signed(mode_signed), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .a_in(a_in), .b_in(b_in),
    .a_out(a_out), .a_out_valid(a_out_valid), .drain_start(drain_start),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last), .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic longint prod(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic sgn);
    if (sgn) return longint'($signed(a)) * longint'($signed(b));
    return longint'(a) * longint'(b);
  endfunction

  function automatic logic [DW-1:0] exp_data(input int k);
    longint v, hi, lo;
    v  = model_acc[k] >>> FS;
    if (mode_signed) begin
      hi = (longint'(1) << (DW - 1)) - 1;
      lo = -(longint'(1) << (DW - 1));
    end else begin
      hi = (longint'(1) << DW) - 1;
      lo = 0;
    end
    if (v > hi) v = hi;
    if (v < lo) v = lo;
    return v[DW-1:0];
  endfunction

  function automatic logic exp_sat(input int k);
    longint v;
    v = model_acc[k] >>> FS;
    if (mode_signed) return (v > (longint'(1) << (DW - 1)) - 1) || (v < -(longint'(1) << (DW - 1)));
    return v > (longint'(1) << DW) - 1;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_b(input logic [DW-1:0] b0, input logic [DW-1:0] b1,
                       input logic [DW-1:0] b2, input logic [DW-1:0] b3);
    b_in = {b3, b2, b1, b0};
  endtask

  function automatic logic [DW-1:0] lane(input int k);
    logic [NPE*DW-1:0] t;
    t = b_in;
    return t[k*DW +: DW];
  endfunction

  task automatic model_add(input logic [DW-1:0] a);
    for (int k = 0; k < NPE; k++) model_acc[k] += prod(a, lane(k), mode_signed);
  endtask

  task automatic beat(input logic [DW-1:0] a);
    in_valid = 1'b1;
    a_in     = a;
    if (in_ready) model_add(a);
    step();
    in_valid = 1'b0;
  endtask

  task automatic clear_pulse();
    clear = 1'b1;
    step();
    clear = 1'b0;
    for (int k = 0; k < NPE; k++) model_acc[k] = 0;
    model_sat = 1'b0;
  endtask

  // Runs one complete drain, recording what the port delivered.
  task automatic do_drain(input bit with_beat, input logic [DW-1:0] beat_a,
                          input int bp_idx, input int bp_cycles, input bit junk);
    got_timeout  = 1'b0;
    got_unstable = 0;
    got_n        = 0;
    out_ready    = 1'b1;
    drain_start  = 1'b1;
    if (with_beat) begin
      in_valid = 1'b1;
      a_in     = beat_a;
      if (in_ready) model_add(beat_a);
    end
    step();
    drain_start = 1'b0;
    in_valid    = 1'b0;
    got_lat     = 1;
    for (int k = 0; k < NPE; k++) begin
      exp_d[k]  = exp_data(k);
      model_sat = model_sat | exp_sat(k);
      model_acc[k] = 0;
    end
    if (junk) begin
      in_valid = 1'b1;
      a_in     = DW'($urandom);
    end
    for (int n = 0; n < NPE; n++) begin
      int w;
      w = 0;
      while (!out_valid && w < 50) begin
        step();
        w++;
        if (n == 0) got_lat++;
      end
      if (!out_valid) begin
        got_timeout = 1'b1;
        break;
      end
      got_data[n] = out_data;
      got_idx[n]  = out_idx;
      got_last[n] = out_last;
      if (n == bp_idx) begin
        out_ready = 1'b0;
        for (int c = 0; c < bp_cycles; c++) begin
          step();
          if (out_valid !== 1'b1 || out_data !== got_data[n] || out_idx !== got_idx[n])
            got_unstable++;
        end
        out_ready = 1'b1;
      end
      if (n == NPE - 1) in_valid = 1'b0;
      step();
      got_n++;
    end
    in_valid = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0; mode_signed = 1'b1; clear = 1'b0; in_valid = 1'b0;
    a_in = '0; b_in = '0; drain_start = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < NPE; k++) model_acc[k] = 0;
    model_sat = 1'b0;
    step(); step();
    @(negedge clk);
    reset_n = 1'b1;
    step();
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset in_ready: got %b expected 1", in_ready); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset out_valid: got %b expected 0", out_valid); end
    n_vec++; if (a_out_valid !== 1'b0 || a_out !== '0) begin n_err++; $display("FAIL reset a_out: got %b/%h expected 0/0000", a_out_valid, a_out); end
    n_vec++; if (sat_flag !== 1'b0 || out_idx !== 2'd0) begin n_err++; $display("FAIL reset sat/idx: got %b/%0d expected 0/0", sat_flag, out_idx); end
  endtask

  task automatic test_dot_product();
    logic [DW-1:0] want [NPE];
    want = '{16'd6, 16'd12, 16'd18, 16'd24};
    mode_signed = 1'b1;
    set_b(16'd1, 16'd2, 16'd3, 16'd4);
    beat(16'd1); beat(16'd2); beat(16'd3);
    do_drain(1'b0, '0, -1, 0, 1'b0);
    n_vec++; if (got_timeout !== 1'b0) begin n_err++; $display("FAIL dot timeout: got %b expected 0", got_timeout); end
    n_vec++; if (got_lat != NPE) begin n_err++; $display("FAIL dot latency: got %0d expected %0d", got_lat, NPE); end
    for (int k = 0; k < NPE; k++) begin
      n_vec++;
      if (got_data[k] !== want[k] || got_idx[k] !== 2'(k) || got_last[k] !== (k == NPE - 1))
        begin n_err++; $display("FAIL dot result[%0d]: got %0d idx %0d last %b expected %0d idx %0d last %b",
                                k, got_data[k], got_idx[k], got_last[k], want[k], k, (k == NPE - 1)); end
    end
    n_vec++; if (sat_flag !== 1'b0) begin n_err++; $display("FAIL dot sat_flag: got %b expected 0", sat_flag); end
    n_vec++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL dot rearm: got valid %b ready %b expected 0 1", out_valid, in_ready); end
  endtask

  task automatic test_saturation();
    logic [DW-1:0] want [3];
    logic [DW-1:0] av   [3];
    logic          sg   [3];
    int            nb   [3];
    want = '{16'h7FFF, 16'h8000, 16'hFFFF};
    av   = '{16'h7FFF, 16'h8000, 16'hFFFF};
    sg   = '{1'b1, 1'b1, 1'b0};
    nb   = '{2, 2, 1};
    for (int t = 0; t < 3; t++) begin
      clear_pulse();
      n_vec++; if (sat_flag !== 1'b0) begin n_err++; $display("FAIL sat cleared[%0d]: got %b expected 0", t, sat_flag); end
      mode_signed = sg[t];
      if (t == 1) set_b(16'd1, 16'd1, 16'd1, 16'd1);
      else        set_b(av[t], av[t], av[t], av[t]);
      for (int j = 0; j < nb[t]; j++) beat(av[t]);
      do_drain(1'b0, '0, -1, 0, 1'b0);
      for (int k = 0; k < NPE; k++) begin
        n_vec++;
        if (got_data[k] !== want[t]) begin n_err++; $display("FAIL sat case%0d data[%0d]: got %h expected %h", t, k, got_data[k], want[t]); end
      end
      n_vec++; if (sat_flag !== 1'b1) begin n_err++; $display("FAIL sat case%0d flag: got %b expected 1", t, sat_flag); end
    end
    clear_pulse();
    mode_signed = 1'b1;
  endtask

  task automatic test_backpressure();
    mode_signed = 1'b1;
    for (int r = 0; r < 2; r++) begin
      set_b(DW'($urandom_range(0, 255)), DW'($urandom_range(0, 255)),
            DW'($urandom_range(0, 255)), DW'($urandom_range(0, 255)));
      for (int j = 0; j < 3; j++) beat(DW'($urandom_range(0, 255)));
      if (r == 0) do_drain(1'b0, '0, 1, 5, 1'b1);
      else        do_drain(1'b0, '0, -1, 0, 1'b0);
      n_vec++; if (got_unstable != 0) begin n_err++; $display("FAIL bp stability: got %0d unstable cycles expected 0", got_unstable); end
      n_vec++; if (got_n != NPE) begin n_err++; $display("FAIL bp deliveries: got %0d expected %0d", got_n, NPE); end
      for (int k = 0; k < NPE; k++) begin
        n_vec++;
        if (got_data[k] !== exp_d[k] || got_idx[k] !== 2'(k))
          begin n_err++; $display("FAIL bp round%0d data[%0d]: got %h idx %0d expected %h idx %0d", r, k, got_data[k], got_idx[k], exp_d[k], k); end
      end
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp extra result: got out_valid %b expected 0", out_valid); end
    end
  endtask

  task automatic test_clear_mid_drain();
    int w;
    set_b(16'd3, 16'd5, 16'd7, 16'd9);
    beat(DW'($urandom_range(1, 100))); beat(DW'($urandom_range(1, 100)));
    drain_start = 1'b1; out_ready = 1'b1;
    step();
    drain_start = 1'b0;
    w = 0;
    while (!out_valid && w < 50) begin step(); w++; end
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL cmd first valid: got %b expected 1", out_valid); end
    step(); step();
    n_vec++; if (out_idx !== 2'd2) begin n_err++; $display("FAIL cmd idx before clear: got %0d expected 2", out_idx); end
    clear_pulse();
    n_vec++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL cmd after clear: got valid %b ready %b expected 0 1", out_valid, in_ready); end
    do_drain(1'b0, '0, -1, 0, 1'b0);
    for (int k = 0; k < NPE; k++) begin
      n_vec++;
      if (got_data[k] !== '0) begin n_err++; $display("FAIL cmd empty drain[%0d]: got %h expected 0000", k, got_data[k]); end
    end
  endtask

  task automatic test_simultaneous();
    clear_pulse();
    mode_signed = 1'b1;
    set_b(16'd1, 16'd1, 16'd1, 16'd1);
    beat(DW'($urandom_range(0, 50))); beat(DW'($urandom_range(0, 50)));
    do_drain(1'b1, 16'd5, -1, 0, 1'b0);
    for (int k = 0; k < NPE; k++) begin
      n_vec++;
      if (got_data[k] !== exp_d[k]) begin n_err++; $display("FAIL simul last beat[%0d]: got %0d expected %0d", k, got_data[k], exp_d[k]); end
    end
    beat(16'd9);
    clear = 1'b1; drain_start = 1'b1;
    step();
    clear = 1'b0; drain_start = 1'b0;
    for (int k = 0; k < NPE; k++) model_acc[k] = 0;
    model_sat = 1'b0;
    for (int c = 0; c < NPE + 2; c++) begin
      n_vec++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL simul clear+drain cyc%0d: got valid %b ready %b expected 0 1", c, out_valid, in_ready); end
      step();
    end
    do_drain(1'b0, '0, -1, 0, 1'b0);
    for (int k = 0; k < NPE; k++) begin
      n_vec++;
      if (got_data[k] !== '0) begin n_err++; $display("FAIL simul acc zero[%0d]: got %h expected 0000", k, got_data[k]); end
    end
  endtask

  task automatic test_async_reset();
    mode_signed = 1'b1;
    set_b(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
    beat(16'h7FFF); beat(16'h7FFF);
    do_drain(1'b0, '0, -1, 0, 1'b0);
    beat(16'h1234); beat(16'h0F0F);
    drain_start = 1'b1;
    step();
    drain_start = 1'b0;
    step();
    #2;
    reset_n = 1'b0;
    #1;
    n_vec++; if (out_valid !== 1'b0 || out_idx !== 2'd0) begin n_err++; $display("FAIL areset valid/idx: got %b/%0d expected 0/0", out_valid, out_idx); end
    n_vec++; if (a_out !== '0 || a_out_valid !== 1'b0) begin n_err++; $display("FAIL areset a_out: got %h/%b expected 0000/0", a_out, a_out_valid); end
    n_vec++; if (sat_flag !== 1'b0) begin n_err++; $display("FAIL areset sat_flag: got %b expected 0", sat_flag); end
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < NPE; k++) model_acc[k] = 0;
    model_sat = 1'b0;
    step();
    n_vec++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_err++; $display("FAIL areset release: got ready %b valid %b expected 1 0", in_ready, out_valid); end
    do_drain(1'b0, '0, -1, 0, 1'b0);
    for (int k = 0; k < NPE; k++) begin
      n_vec++;
      if (got_data[k] !== '0) begin n_err++; $display("FAIL areset acc[%0d]: got %h expected 0000", k, got_data[k]); end
    end
  endtask

  task automatic test_cascade();
    logic [DW-1:0] h_a [40];
    logic          h_v [40];
    for (int i = 0; i < 40; i++) begin
      h_v[i]   = 1'($urandom_range(0, 1));
      h_a[i]   = DW'($urandom);
      in_valid = h_v[i];
      a_in     = h_a[i];
      step();
      if (i >= 3) begin
        n_vec++;
        if (a_out !== h_a[i-3] || a_out_valid !== h_v[i-3])
          begin n_err++; $display("FAIL cascade step%0d: got %h/%b expected %h/%b", i, a_out, a_out_valid, h_a[i-3], h_v[i-3]); end
      end
    end
    in_valid = 1'b0;
    clear_pulse();
  endtask

  task automatic test_random();
    for (int r = 0; r < 8; r++) begin
      int nb, bpi, bpc;
      clear_pulse();
      mode_signed = 1'($urandom_range(0, 1));
      set_b(DW'($urandom), DW'($urandom), DW'($urandom), DW'($urandom));
      nb = $urandom_range(1, 5);
      for (int j = 0; j < nb; j++) begin
        if ($urandom_range(0, 2) == 0) step();
        if ($urandom_range(0, 1) == 1) beat(DW'($urandom));
        else                           beat(DW'($urandom_range(0, 300)));
      end
      bpi = $urandom_range(0, NPE - 1);
      bpc = $urandom_range(0, 3);
      do_drain(1'($urandom_range(0, 1)), DW'($urandom), bpi, bpc, 1'($urandom_range(0, 1)));
      n_vec++; if (got_timeout !== 1'b0 || got_unstable != 0) begin n_err++; $display("FAIL random%0d port: got timeout %b unstable %0d expected 0 0", r, got_timeout, got_unstable); end
      for (int k = 0; k < NPE; k++) begin
        n_vec++;
        if (got_data[k] !== exp_d[k] || got_idx[k] !== 2'(k) || got_last[k] !== (k == NPE - 1))
          begin n_err++; $display("FAIL random%0d data[%0d]: got %h idx %0d last %b expected %h idx %0d last %b",
                                  r, k, got_data[k], got_idx[k], got_last[k], exp_d[k], k, (k == NPE - 1)); end
      end
      n_vec++; if (sat_flag !== model_sat) begin n_err++; $display("FAIL random%0d sat_flag: got %b expected %b", r, sat_flag, model_sat); end
    end
  endtask

  initial begin
    test_reset();
    test_dot_product();
    test_saturation();
    test_backpressure();
    test_clear_mid_drain();
    test_simultaneous();
    test_async_reset();
    test_cascade();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
